// File: rtl/mem_pkg.sv
// Shared types and constants for the memory stage.
// State encoding, load/store funct3 codes, the MEM/WB bundle and an
// access-size decoder used by both byte-enable generation and the
// optional misalignment check (MEM_MISALIGN_TRAP_EN).
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access sizes as returned by access_size().
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Fixed-width part of the MEM/WB bundle; the XLEN-wide data lives
  // beside it so the package stays independent of XLEN.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        reg_write;
  } mem_wb_t;

  // Low two funct3 bits give the size; 011/110/111 fall into word.
  function automatic logic [1:0] access_size(logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/load_align_s.sv
// Load data alignment: selects the addressed byte/half lane of the
// returned word and sign- or zero-extends it according to funct3.
module load_align_s
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      off_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Half lanes are selected by off[1] only; off[0] is ignored for halves.
  assign byte_v = rdata_i[{off_i, 3'b000} +: 8];
  assign half_v = rdata_i[{off_i[1], 4'b0000} +: 16];

  // Extend the selected lane; any encoding that is not a byte/half load
  // passes the whole word.
  always_comb begin
    case (funct3_i)
      F3_B:    data_o = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_H:    data_o = {{(XLEN-16){half_v[15]}}, half_v};
      F3_BU:   data_o = {{(XLEN-8){1'b0}}, byte_v};
      F3_HU:   data_o = {{(XLEN-16){1'b0}}, half_v};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_s.sv
// MEM pipeline stage: consumes the held EX/MEM entry, runs loads and
// stores on a req/gnt/rvalid bus, aligns load data and registers the
// MEM/WB bundle. stall_mem holds EX/MEM while an access is in flight.
// Optional build macro MEM_MISALIGN_TRAP_EN adds wb_trap and turns
// misaligned half/word accesses into a trap instead of a bus access.
module mem_stage_s
  import mem_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BE_W = XLEN / 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mem_isValid,
  input  logic [31:0]     mem_pc,
  input  logic [31:0]     mem_instr,
  input  logic [4:0]      mem_rd,
  input  logic            mem_mem_read,
  input  logic            mem_mem_write,
  input  logic            mem_reg_write,
  input  logic [XLEN-1:0] mem_result,
  input  logic [XLEN-1:0] mem_sData,
  output logic            stall_mem,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [BE_W-1:0] dmem_be,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_isValid,
  output logic [31:0]     wb_pc,
  output logic [31:0]     wb_instr,
  output logic [4:0]      wb_rd,
  output logic            wb_reg_write,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic            wb_trap,
`endif
  output logic [XLEN-1:0] wb_data
);

  state_e          state_q, state_d;
  mem_wb_t         wb_q, wb_d;
  mem_wb_t         cap_q, cap_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0] be_q, be_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;

  logic [2:0]      f3_in;
  logic [1:0]      off_in;
  logic [1:0]      size_in;
  logic            is_mem;
  logic            issue;
  logic [BE_W-1:0] be_in;
  logic [XLEN-1:0] wdata_in;
  mem_wb_t         entry_wb;
  logic [XLEN-1:0] load_data;

  assign f3_in   = mem_instr[14:12];
  assign off_in  = mem_result[1:0];
  assign size_in = access_size(f3_in);
  assign is_mem  = mem_isValid & (mem_mem_read | mem_mem_write);

  assign entry_wb = '{valid:     mem_isValid,
                      pc:        mem_pc,
                      instr:     mem_instr,
                      rd:        mem_rd,
                      reg_write: mem_reg_write};

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign;
  logic trap_q, trap_d;

  assign misalign = ((size_in == SZ_HALF) & off_in[0]) |
                    ((size_in == SZ_WORD) & (|off_in));
  assign issue    = is_mem & ~misalign;
  assign wb_trap  = trap_q;
`else
  assign issue    = is_mem;
`endif

  // Lane enables and replicated store data for the incoming entry;
  // offset bits below the access size are dropped.
  always_comb begin
    case (size_in)
      SZ_BYTE: begin
        be_in    = BE_W'(1) << off_in;
        wdata_in = {BE_W{mem_sData[7:0]}};
      end
      SZ_HALF: begin
        be_in    = BE_W'(3) << {off_in[1], 1'b0};
        wdata_in = {(BE_W/2){mem_sData[15:0]}};
      end
      default: begin
        be_in    = '1;
        wdata_in = mem_sData;
      end
    endcase
  end

  load_align_s #(.XLEN(XLEN)) u_load_align (
    .rdata_i  (dmem_rdata),
    .funct3_i (f3_q),
    .off_i    (off_q),
    .data_o   (load_data)
  );

  // FSM next state, stall and MEM/WB next values.
  always_comb begin
    // NOTE: every signal assigned below gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    state_d   = state_q;
    wb_d      = wb_q;
    wb_d.valid = 1'b0;
    wb_data_d = wb_data_q;
    cap_d     = cap_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    we_d      = we_q;
    f3_d      = f3_q;
    off_d     = off_q;
    stall_mem = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    trap_d    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (issue) begin
          stall_mem = 1'b1;
          cap_d     = entry_wb;
          addr_d    = mem_result;
          wdata_d   = wdata_in;
          be_d      = be_in;
          // Read and write together is handled as a store.
          we_d      = mem_mem_write;
          f3_d      = f3_in;
          off_d     = off_in;
          state_d   = REQ;
`ifdef MEM_MISALIGN_TRAP_EN
        end else if (is_mem) begin
          // Misaligned access retires at once as a trap carrying the
          // faulting address, with no bus traffic and no stall.
          wb_d           = entry_wb;
          wb_d.reg_write = 1'b0;
          wb_data_d      = mem_result;
          trap_d         = 1'b1;
`endif
        end else if (mem_isValid) begin
          wb_d      = entry_wb;
          wb_data_d = mem_result;
        end
      end

      REQ: begin
        stall_mem = 1'b1;
        if (dmem_gnt) begin
          if (we_q) begin
            stall_mem      = 1'b0;
            wb_d           = cap_q;
            wb_d.reg_write = 1'b0;
            wb_data_d      = addr_q;
            state_d        = IDLE;
          end else begin
            state_d = WAIT_RSP;
          end
        end
      end

      WAIT_RSP: begin
        stall_mem = 1'b1;
        if (dmem_rvalid) begin
          stall_mem = 1'b0;
          wb_d      = cap_q;
          wb_data_d = load_data;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and pipeline registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the
    // pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: the captured address/data/enable registers are cleared too,
      // so the bus outputs read 0 after reset rather than stale values.
      state_q   <= IDLE;
      wb_q      <= '0;
      wb_data_q <= '0;
      cap_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      we_q      <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      trap_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      wb_q      <= wb_d;
      wb_data_q <= wb_data_d;
      cap_q     <= cap_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      we_q      <= we_d;
      f3_q      <= f3_d;
      off_q     <= off_d;
`ifdef MEM_MISALIGN_TRAP_EN
      trap_q    <= trap_d;
`endif
    end
  end

  assign dmem_req     = (state_q == REQ);
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign dmem_be      = be_q;

  assign wb_isValid   = wb_q.valid;
  assign wb_pc        = wb_q.pc;
  assign wb_instr     = wb_q.instr;
  assign wb_rd        = wb_q.rd;
  assign wb_reg_write = wb_q.reg_write;
  assign wb_data      = wb_data_q;

endmodule

// File: tb/tb_mem_stage_s.sv
// Bench for mem_stage_s: directed cases plus random entries checked
// against a lane/size reference model. Honours MEM_MISALIGN_TRAP_EN.
module tb_mem_stage_s;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_isValid;
  logic [31:0] mem_pc, mem_instr;
  logic [4:0]  mem_rd;
  logic        mem_mem_read, mem_mem_write, mem_reg_write;
  logic [31:0] mem_result, mem_sData;
  logic        stall_mem;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_isValid;
  logic [31:0] wb_pc, wb_instr;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_data;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        wb_trap;
`endif

  int n_vec = 0;
  int n_err = 0;

  mem_stage_s dut (
    .clk           (clk),
    .reset         (reset),
    .mem_isValid   (mem_isValid),
    .mem_pc        (mem_pc),
    .mem_instr     (mem_instr),
    .mem_rd        (mem_rd),
    .mem_mem_read  (mem_mem_read),
    .mem_mem_write (mem_mem_write),
    .mem_reg_write (mem_reg_write),
    .mem_result    (mem_result),
    .mem_sData     (mem_sData),
    .stall_mem     (stall_mem),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_be       (dmem_be),
    .dmem_gnt      (dmem_gnt),
    .dmem_rvalid   (dmem_rvalid),
    .dmem_rdata    (dmem_rdata),
    .wb_isValid    (wb_isValid),
    .wb_pc         (wb_pc),
    .wb_instr      (wb_instr),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
`ifdef MEM_MISALIGN_TRAP_EN
    .wb_trap       (wb_trap),
`endif
    .wb_data       (wb_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  // First byte lane touched: offset rounded down to the access size.
  function automatic int base_lane(input logic [2:0] f3, input logic [31:0] addr);
    int nb = nbytes(f3);
    return (int'(addr[1:0]) / nb) * nb;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
    logic [3:0] be = '0;
    int b = base_lane(f3, addr);
    for (int i = 0; i < 4; i++)
      if (i >= b && i < b + nbytes(f3)) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] w;
    int nb = nbytes(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % nb) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rd);
    int nb = nbytes(f3);
    logic [31:0] v = rd >> (8 * base_lane(f3, addr));
    logic [31:0] mask;
    if (nb == 4) return rd;
    mask = (32'd1 << (8 * nb)) - 32'd1;
    v = v & mask;
    if (!f3[2] && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic model_misaligned(input logic [2:0] f3, input logic [31:0] addr);
`ifdef MEM_MISALIGN_TRAP_EN
    return (int'(addr[1:0]) % nbytes(f3)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- stimulus ----------------
  task automatic check_zero_state(input string tag);
    check({tag, "_wb_valid"}, wb_isValid, 0);
    check({tag, "_wb_data"},  wb_data, 0);
    check({tag, "_wb_pc"},    wb_pc, 0);
    check({tag, "_wb_instr"}, wb_instr, 0);
    check({tag, "_wb_rd"},    wb_rd, 0);
    check({tag, "_wb_rw"},    wb_reg_write, 0);
    check({tag, "_req"},      dmem_req, 0);
    check({tag, "_we"},       dmem_we, 0);
    check({tag, "_be"},       dmem_be, 0);
    check({tag, "_addr"},     dmem_addr, 0);
    check({tag, "_wdata"},    dmem_wdata, 0);
    check({tag, "_stall"},    stall_mem, 0);
  endtask

  // Presents one entry at a negedge, plays the memory slave with the given
  // grant/response delays and checks every cycle until the entry retires.
  task automatic do_entry(input logic v, input logic rdf, input logic wrf, input logic rw,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [31:0] rdat,
                          input logic [4:0] rd, input int ngnt, input int nrv);
    logic [31:0] pc = $urandom;
    logic [31:0] instr = $urandom;
    logic is_mem, store, trap;
    instr[14:12] = f3;
    is_mem = v && (rdf || wrf);
    store  = wrf;
    trap   = is_mem && model_misaligned(f3, addr);

    mem_isValid = v;  mem_pc = pc;  mem_instr = instr;  mem_rd = rd;
    mem_mem_read = rdf;  mem_mem_write = wrf;  mem_reg_write = rw;
    mem_result = addr;  mem_sData = sd;
    dmem_gnt = 1'b0;  dmem_rvalid = 1'b0;
    #1;
    check("idle_stall", stall_mem, is_mem && !trap);
    check("idle_req", dmem_req, 0);
    @(posedge clk); @(negedge clk);

    if (!is_mem || trap) begin
      check("wb_valid", wb_isValid, v);
      if (v) begin
        check("wb_data", wb_data, addr);
        check("wb_rd", wb_rd, rd);
        check("wb_pc", wb_pc, pc);
        check("wb_instr", wb_instr, instr);
        check("wb_rw", wb_reg_write, trap ? 1'b0 : rw);
`ifdef MEM_MISALIGN_TRAP_EN
        check("wb_trap", wb_trap, trap);
`endif
      end
      return;
    end

    for (int k = 0; k <= ngnt; k++) begin
      dmem_gnt    = (k == ngnt);
      dmem_rvalid = 1'($urandom % 2);
      dmem_rdata  = $urandom;
      #1;
      check("req_req", dmem_req, 1);
      check("req_addr", dmem_addr, addr);
      check("req_be", dmem_be, model_be(f3, addr));
      check("req_we", dmem_we, store);
      if (store) check("req_wdata", dmem_wdata, model_wdata(f3, sd));
      check("req_stall", stall_mem, !(dmem_gnt && store));
      check("req_wb_valid", wb_isValid, 0);
      @(posedge clk); @(negedge clk);
    end
    dmem_gnt = 1'b0;

    if (!store) begin
      for (int j = 0; j <= nrv; j++) begin
        dmem_rvalid = (j == nrv);
        dmem_rdata  = (j == nrv) ? rdat : $urandom;
        #1;
        check("wait_req", dmem_req, 0);
        check("wait_stall", stall_mem, j != nrv);
        check("wait_wb_valid", wb_isValid, 0);
        @(posedge clk); @(negedge clk);
      end
    end
    dmem_rvalid = 1'b0;

    check("done_valid", wb_isValid, 1);
    check("done_data", wb_data, store ? addr : model_load(f3, addr, rdat));
    check("done_rd", wb_rd, rd);
    check("done_pc", wb_pc, pc);
    check("done_instr", wb_instr, instr);
    check("done_rw", wb_reg_write, store ? 1'b0 : rw);
`ifdef MEM_MISALIGN_TRAP_EN
    check("done_trap", wb_trap, 0);
`endif
  endtask

  initial begin
    logic rv, rdf, wrf;
    int   kind;

    reset = 1'b1;
    mem_isValid = 0; mem_pc = 0; mem_instr = 0; mem_rd = 0;
    mem_mem_read = 0; mem_mem_write = 0; mem_reg_write = 0;
    mem_result = 0; mem_sData = 0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero_state("por");
    reset = 1'b0;

    // ALU op, SB, LB/LBU, slow LW, LW at a misaligned address
    do_entry(1, 0, 0, 1, 3'b000, 32'h1234, 0, 0, 5'd5, 0, 0);
    do_entry(1, 0, 1, 1, 3'b000, 32'h1003, 32'h000000AB, 0, 5'd7, 0, 0);
    do_entry(1, 1, 0, 1, 3'b000, 32'h2002, 0, 32'h0080_0000, 5'd8, 0, 0);
    do_entry(1, 1, 0, 1, 3'b100, 32'h2002, 0, 32'h0080_0000, 5'd9, 0, 0);
    do_entry(1, 1, 0, 1, 3'b010, 32'h1000, 0, 32'hDEAD_BEEF, 5'd10, 3, 2);
    do_entry(1, 1, 0, 1, 3'b010, 32'h3002, 0, 32'h1357_9BDF, 5'd11, 1, 0);
    do_entry(1, 1, 1, 1, 3'b001, 32'h4006, 32'h0000_8765, 0, 5'd12, 2, 0);

    // Reset while waiting for a load response; the late rvalid is ignored.
    do_entry(0, 0, 0, 0, 3'b000, 0, 0, 0, 5'd0, 0, 0);
    mem_isValid = 1; mem_mem_read = 1; mem_mem_write = 0; mem_reg_write = 1;
    mem_instr = 32'h0000_2003; mem_result = 32'h40; mem_rd = 5'd3;
    @(posedge clk); @(negedge clk);
    dmem_gnt = 1;
    @(posedge clk); @(negedge clk);
    dmem_gnt = 0;
    reset = 1;
    @(posedge clk); @(negedge clk);
    mem_isValid = 0;
    #1;
    check_zero_state("rst_mid");
    reset = 0;
    dmem_rvalid = 1; dmem_rdata = 32'hCAFE_F00D;
    @(posedge clk); @(negedge clk);
    check("late_rvalid_wb", wb_isValid, 0);
    check("late_rvalid_req", dmem_req, 0);
    check("late_rvalid_data", wb_data, 0);
    dmem_rvalid = 0;

    for (int i = 0; i < 300; i++) begin
      rv   = ($urandom % 8) != 0;
      kind = int'($urandom % 4);
      rdf  = (kind == 1) || (kind == 3);
      wrf  = (kind >= 2);
      do_entry(rv, rdf, wrf, 1'($urandom % 2), 3'($urandom % 8), $urandom, $urandom,
               $urandom, 5'($urandom % 32), int'($urandom % 4), int'($urandom % 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage_s.md
Name: mem_stage_s

Overview:
- Consumer end of the EX/MEM pipeline register.
- Takes the held EX/MEM bundle and runs loads and stores on a req/gnt/rvalid data-memory bus.
- Aligns and extends load data, then registers the MEM/WB bundle.
- Drives stall_mem back to the EX/MEM register so it holds while a memory access is outstanding.

Parameters:
- XLEN, 32, datapath/address width.
- BE_W, XLEN/8, byte-enable width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- mem_isValid  in  1  EX/MEM entry valid
- mem_pc, mem_instr  in  32 each  PC and instruction of the entry
- mem_rd  in  5  destination register
- mem_mem_read, mem_mem_write, mem_reg_write  in  1 each  control bits
- mem_result  in  XLEN  ALU result; the memory address for loads and stores
- mem_sData  in  XLEN  store data
- stall_mem  out  1  EX/MEM must hold its contents this cycle
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  XLEN  byte address
- dmem_wdata  out  XLEN  lane-replicated store data
- dmem_be  out  BE_W  byte enables
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  XLEN  read data
- wb_isValid  out  1  MEM/WB entry valid
- wb_pc, wb_instr  out  32 each  passed through from the entry
- wb_rd  out  5  passed through from the entry
- wb_reg_write  out  1  passed through from the entry
- wb_data  out  XLEN  load data, or mem_result for non-loads

Behaviour:
- Reset is synchronous, active-high, on clk.
- On reset:
  - State goes to IDLE.
  - All wb_* outputs are 0.
  - dmem_req, dmem_we and dmem_be are 0; address and data registers are 0.
  - A reset mid-access abandons the access. A later dmem_rvalid arrives in IDLE and is ignored.
- Width and lane rules:
  - funct3 = mem_instr[14:12]; off = mem_result[1:0].
  - 000 selects byte: dmem_be = 0001<<off; dmem_wdata = {4{sData[7:0]}}.
  - 001 selects half: dmem_be = 0011<<(2*off[1]); dmem_wdata = {2{sData[15:0]}}.
  - 010 selects word: dmem_be = 1111. Other encodings (011, 110, 111) are also treated as word.
  - Loads: 000 LB and 001 LH sign-extend the selected lane; 100 LBU and 101 LHU zero-extend; 010 LW passes the word.
  - Without the optional feature, off bits below the access size are ignored: half ignores off[0], word ignores off.
- A memory op is mem_isValid & (mem_mem_read | mem_mem_write).
- If both mem_mem_read and mem_mem_write are set, the entry is treated as a store.
- FSM states:
  - IDLE:
    - Non-memory valid entry: the next edge loads wb_* with wb_data = mem_result. stall_mem = 0. Latency is 1 cycle.
    - Memory op: stall_mem = 1. The next edge captures addr, wdata, be, we, funct3, off and the wb passthrough fields into internal registers, then goes to REQ.
    - No valid entry: wb_isValid <= 0 (bubble).
  - REQ:
    - dmem_req = 1, driven from the registered fields, which stay stable until gnt.
    - stall_mem = 1 except in the completing cycle, so that a following entry does not issue while the load is outstanding.
    - gnt & store: stall_mem = 0. The next edge writes wb_* with wb_reg_write = 0 and returns to IDLE.
    - gnt & load: goes to WAIT_RSP; stall_mem stays 1.
    - dmem_rvalid in REQ is ignored.
  - WAIT_RSP:
    - dmem_req = 0.
    - rvalid: stall_mem = 0. The next edge writes wb_data = the extracted load data and returns to IDLE.
    - No rvalid: stall_mem = 1; wb_isValid <= 0 each cycle.
- Minimum latency: store 2 cycles, load 3 cycles.
- wb_isValid pulses for exactly one cycle per retired entry.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Enabled:
  - Adds output wb_trap (1 bit, reset 0).
  - A memory op with half & off[0], or word & off != 0, issues no request and does not stall.
  - The next edge writes wb_isValid = 1, wb_trap = 1, wb_reg_write = 0, wb_data = mem_result (the faulting address).
- Disabled:
  - No wb_trap port.
  - The access issues with the low-bit truncation described under Behaviour.

Decomposition:
- Package mem_pkg holds:
  - The state enum (IDLE, REQ, WAIT_RSP).
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - A mem_wb bundle struct.
- One sub-module, load_align_s: combinational (rdata, funct3, off) -> extended load data.
- Byte-enable and wdata generation stay inline in mem_stage_s.

Test Plan:
- ALU op: mem_isValid = 1, read = write = 0, result = 0x1234, rd = 5, reg_write = 1 -> next cycle wb_isValid = 1, wb_data = 0x1234, wb_rd = 5, stall_mem never asserted.
- SB: addr 0x1003, sData 0xAB, gnt on the first REQ cycle -> dmem_be = 1000, dmem_wdata = 0xABABABAB, dmem_we = 1; stall_mem high for 1 cycle; wb_reg_write = 0.
- LB/LBU: addr 0x2002, rdata 0x00800000, rvalid 1 cycle after gnt -> LB gives wb_data = 0xFFFFFF80; LBU gives 0x00000080.
- LW with gnt held low 3 cycles and rvalid 2 cycles later: rdata 0xDEADBEEF -> dmem_req held with a stable addr; stall_mem high until the rvalid cycle; a single wb pulse with 0xDEADBEEF.
- Reset asserted while in WAIT_RSP, then rvalid arrives -> all outputs 0; rvalid ignored; no wb pulse.
- MEM_MISALIGN_TRAP_EN: LW at 0x3002 -> no dmem_req; next cycle wb_trap = 1, wb_data = 0x3002, wb_reg_write = 0. Without the macro, the same LW issues with dmem_be = 1111.
